// File: rtl/reg_bank_uart_ctrl.sv
// UART-framed register bank: collects payload bytes plus a control byte, executes
// a register read or write, and streams the response back through the UART transmitter.
module reg_bank_uart_ctrl #(
   parameter int PAYLOAD_BYTES = 4,
   parameter int NUM_REGS = 16,
   parameter int REG_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALS = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          received,
   input  logic [7:0]                    rx_byte,
   input  logic                          is_transmitting,
   output logic                          transmit,
   output logic [7:0]                    tx_byte,
   output logic [NUM_REGS*REG_WIDTH-1:0] regs,
   output logic [NUM_REGS-1:0]           upd,
   output logic                          rx_done,
   output logic                          frame_err
);

   localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LEFT_W = $clog2(PAYLOAD_BYTES + 2);
   localparam int RESP_W = REG_WIDTH + 8;

   typedef enum logic [1:0] {RECV, EXEC, SEND, SEND_WAIT} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [TMR_W-1:0]     timer;
   logic [REG_WIDTH-1:0] payload;
   logic [7:0]           ctrl;
   logic [7:0]           csum;
   logic [RESP_W-1:0]    resp;
   logic [LEFT_W-1:0]    left;
   logic [1:0]           wait_cnt;
   logic                 seen_busy;
   logic                 rd_hit;
   logic [REG_WIDTH-1:0] rd_val;

   // Index decode shared by reads and writes; an index past the bank never hits.
   always_comb begin
      rd_hit = 1'b0;
      rd_val = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (ctrl[5:0] == 6'(k)) begin
            rd_hit = 1'b1;
            rd_val = regs[k*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RECV;
         cnt       <= '0;
         timer     <= '0;
         payload   <= '0;
         ctrl      <= '0;
         csum      <= '0;
         resp      <= '0;
         left      <= '0;
         wait_cnt  <= '0;
         seen_busy <= 1'b0;
         regs      <= RESET_VALS;
         upd       <= '0;
         transmit  <= 1'b0;
         tx_byte   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         upd      <= '0;
         transmit <= 1'b0;
         if (received && state != RECV) frame_err <= 1'b1;

         case (state)
            RECV: begin
               if (received) begin
                  timer <= '0;
                  if (cnt == CNT_W'(PAYLOAD_BYTES)) begin
                     // upd is raised here so its pulse lines up with the EXEC cycle.
                     ctrl    <= rx_byte;
                     cnt     <= '0;
                     rx_done <= 1'b1;
                     state   <= EXEC;
                     for (int k = 0; k < NUM_REGS; k++)
                        upd[k] <= !rx_byte[7] && (rx_byte[5:0] == 6'(k));
                  end else begin
                     payload[8*cnt +: 8] <= rx_byte;
                     csum <= ((cnt == '0) ? 8'h00 : csum) + rx_byte;
                     cnt  <= cnt + 1'b1;
                  end
               end else if (cnt != '0) begin
                  if (timer >= TMR_W'(TIMEOUT_CYCLES)) begin
                     cnt       <= '0;
                     timer     <= '0;
                     frame_err <= 1'b1;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end

            EXEC: begin
               if (!ctrl[7] && rd_hit) begin
                  for (int k = 0; k < NUM_REGS; k++)
                     if (upd[k]) regs[k*REG_WIDTH +: REG_WIDTH] <= payload;
                  resp <= {{REG_WIDTH{1'b0}}, csum};
                  left <= LEFT_W'(1);
               end else if (ctrl[7] && rd_hit) begin
                  resp <= {csum, rd_val};
                  left <= LEFT_W'(PAYLOAD_BYTES + 1);
               end else begin
                  resp <= {{REG_WIDTH{1'b0}}, csum ^ 8'hFF};
                  left <= LEFT_W'(1);
               end
               state <= SEND;
            end

            SEND: begin
               if (!is_transmitting) begin
                  transmit  <= 1'b1;
                  tx_byte   <= resp[7:0];
                  resp      <= resp >> 8;
                  left      <= left - 1'b1;
                  wait_cnt  <= '0;
                  seen_busy <= 1'b0;
                  state     <= SEND_WAIT;
               end
            end

            SEND_WAIT: begin
               // A transmitter that never reports busy within 4 cycles is assumed done.
               if (seen_busy ? !is_transmitting
                             : (!is_transmitting && wait_cnt == 2'd3)) begin
                  if (left == '0) begin
                     state   <= RECV;
                     rx_done <= 1'b0;
                  end else begin
                     state <= SEND;
                  end
               end else begin
                  if (is_transmitting) seen_busy <= 1'b1;
                  if (wait_cnt != 2'd3) wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: state <= RECV;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_uart_ctrl.sv
// Randomized bench for reg_bank_uart_ctrl: a frame-level reference model predicts
// response bytes and update strobes; a monitor compares them as the DUT emits them.
module tb_reg_bank_uart_ctrl;

   localparam int P  = 4;
   localparam int NR = 16;
   localparam int W  = 32;
   localparam int TO = 40;

   function automatic logic [NR*W-1:0] mk_rv();
      logic [NR*W-1:0] v;
      for (int k = 0; k < NR; k++) v[k*W +: W] = 32'hC0DE_0000 | k;
      return v;
   endfunction
   localparam logic [NR*W-1:0] RV = mk_rv();

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          received = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          is_transmitting = 1'b0;
   logic          transmit;
   logic [7:0]    tx_byte;
   logic [NR*W-1:0] regs;
   logic [NR-1:0] upd;
   logic          rx_done;
   logic          frame_err;

   reg_bank_uart_ctrl #(
      .PAYLOAD_BYTES(P), .NUM_REGS(NR), .REG_WIDTH(W),
      .TIMEOUT_CYCLES(TO), .RESET_VALS(RV)
   ) dut (
      .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
      .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
      .regs(regs), .upd(upd), .rx_done(rx_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   logic [7:0]    exp_q[$];
   logic [NR-1:0] exp_upd_q[$];
   logic [W-1:0]  mdl[NR];
   int            n_checks = 0;
   int            n_pass = 0;
   bit            uart_mute = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h required=%0h", name, got, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NR; k++) mdl[k] = RV[k*W +: W];
      exp_q.delete();
      exp_upd_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      received = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_transmit"}, transmit, 0);
      check({tag, "_tx_byte"}, tx_byte, 0);
      check({tag, "_rx_done"}, rx_done, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_upd"}, upd, 0);
      for (int k = 0; k < NR; k++)
         check($sformatf("%s_regs%0d", tag, k), regs[k*W +: W], RV[k*W +: W]);
   endtask

   task automatic check_regs();
      for (int k = 0; k < NR; k++)
         check($sformatf("regs%0d", k), regs[k*W +: W], mdl[k]);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      received = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      received = 1'b0;
      rx_byte  = 8'($urandom);
   endtask

   // Reference: checksum is the byte sum; writes to a real register echo it,
   // reads return the register LSB first then the checksum, bad indices return ~checksum.
   task automatic send_frame(input logic [W-1:0] pay, input logic [7:0] ctl, input int max_gap);
      logic [7:0] cs;
      int idx;
      cs = 8'h00;
      for (int i = 0; i < P; i++) cs = cs + pay[8*i +: 8];
      idx = int'(ctl[5:0]);
      if (idx >= NR) begin
         exp_q.push_back(cs ^ 8'hFF);
      end else if (!ctl[7]) begin
         mdl[idx] = pay;
         exp_upd_q.push_back(NR'(1) << idx);
         exp_q.push_back(cs);
      end else begin
         for (int i = 0; i < P; i++) exp_q.push_back(mdl[idx][8*i +: 8]);
         exp_q.push_back(cs);
      end
      for (int i = 0; i < P; i++) begin
         drive_byte(pay[8*i +: 8]);
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
      end
      drive_byte(ctl);
      check("rx_done_rise", rx_done, 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!rx_done && exp_q.size() == 0 && exp_upd_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check("drain", ok, 1);
   endtask

   task automatic wait_transmit(output bit ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (transmit) begin
            ok = 1;
            break;
         end
      end
   endtask

   // UART transmitter model: goes busy the cycle after a request unless muted.
   initial begin
      forever begin
         @(negedge clk);
         if (transmit && !uart_mute) begin
            is_transmitting = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            is_transmitting = 1'b0;
         end
      end
   end

   // Monitor: every transmit and upd pulse is matched against the expected queues.
   initial begin
      bit prev_tx;
      prev_tx = 0;
      forever begin
         @(negedge clk);
         if (transmit) begin
            check("tx_spacing", prev_tx, 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL tx_unexpected got=%0h required=no_byte", tx_byte);
            end else begin
               check("tx_byte", tx_byte, exp_q.pop_front());
            end
         end
         if (upd != '0) begin
            if (exp_upd_q.size() == 0) begin
               n_checks++;
               $display("FAIL upd_unexpected got=%0h required=0", upd);
            end else begin
               check("upd", upd, exp_upd_q.pop_front());
            end
         end
         prev_tx = transmit;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      model_reset();
      @(negedge clk);
      do_reset();
      check_reset_outputs("reset");

      // Directed write, read, and out-of-range accesses.
      send_frame(32'h04030201, 8'h05, 0);
      drain();
      check_regs();
      send_frame(32'h00000000, 8'h85, 2);
      drain();
      send_frame(32'h40302010, 8'h3F, 1);
      drain();
      check_regs();
      send_frame(32'hDEADBEEF, 8'hBF, 1);
      drain();
      send_frame(32'h11223344, 8'h47, 0);
      drain();
      send_frame(32'h0, 8'hC7, 0);
      drain();
      check_regs();

      // Randomized frames, with a silent transmitter part of the time.
      for (int n = 0; n < 40; n++) begin
         uart_mute = ($urandom_range(0, 3) == 0);
         send_frame(32'($urandom), {1'($urandom), 1'($urandom), 6'($urandom_range(0, 20))}, 3);
         drain();
      end
      uart_mute = 0;
      check_regs();
      check("no_err_yet", frame_err, 0);

      // Idle timeout on a partial frame, then a clean frame.
      drive_byte(8'hAA);
      drive_byte(8'hBB);
      repeat (TO / 2) @(negedge clk);
      check("timeout_early", frame_err, 0);
      repeat (TO + 3 - TO / 2) @(negedge clk);
      check("timeout_err", frame_err, 1);
      send_frame(32'h89ABCDEF, 8'h02, 1);
      drain();
      send_frame(32'h0, 8'h82, 1);
      drain();
      check_regs();
      check("timeout_sticky", frame_err, 1);

      // Overrun while waiting on the transmitter.
      do_reset();
      check("err_cleared", frame_err, 0);
      send_frame(32'h55667788, 8'h09, 0);
      drain();
      send_frame(32'h0, 8'h89, 0);
      wait_transmit(ok);
      check("overrun_tx_seen", ok, 1);
      drive_byte(8'h77);
      drain();
      check("overrun_err", frame_err, 1);
      send_frame(32'h0A0B0C0D, 8'h0A, 2);
      drain();
      check_regs();

      // Reset in the middle of a frame.
      drive_byte(8'h01);
      drive_byte(8'h02);
      drive_byte(8'h03);
      do_reset();
      check_reset_outputs("midframe");
      send_frame(32'hFEEDF00D, 8'h03, 1);
      drain();
      send_frame(32'h0, 8'h83, 1);
      drain();
      check_regs();

      // Reset in the middle of a response: nothing further may be sent.
      send_frame(32'h0, 8'h83, 0);
      wait_transmit(ok);
      check("midsend_tx_seen", ok, 1);
      @(negedge clk);
      do_reset();
      repeat (20) @(negedge clk);
      check("midsend_rx_done", rx_done, 0);
      check("midsend_regs3", regs[3*W +: W], RV[3*W +: W]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
